// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with parallel load, programmable wrap limit and
// cascadable terminal count. Define BCD_SAT_EN to saturate at the bounds instead of wrapping.
module bcd_counter_multi #(
  parameter int                      NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0] LIMIT      = {NUM_DIGITS{4'h9}}
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      ENABLE,
  input  logic                      LOAD,
  input  logic                      UP,
  input  logic [4*NUM_DIGITS-1:0]   D,
  output logic [4*NUM_DIGITS-1:0]   Q,
  output logic                      CO,
  output logic                      ERR
);

  localparam int W = 4 * NUM_DIGITS;

  function automatic logic bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_multi: NUM_DIGITS must be 1..8");
  end
  if (!bcd_ok(LIMIT) || LIMIT == '0) begin : g_bad_limit
    $error("bcd_counter_multi: LIMIT must be nonzero valid BCD");
  end

  logic [W-1:0]            q_q, q_d;
  logic                    err_q, err_d;
  logic [W-1:0]            inc, dec;
  logic [NUM_DIGITS-1:0]   cy, bw;
  logic                    at_max, at_zero, d_ok;
  logic [W-1:0]            up_wrap, dn_wrap;

  // A digit steps only while every lower digit is at its rollover value.
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [3:0] dig;
    assign dig = q_q[4*g +: 4];
    if (g > 0) begin : g_chain
      assign cy[g] = cy[g-1] & (q_q[4*(g-1) +: 4] == 4'd9);
      assign bw[g] = bw[g-1] & (q_q[4*(g-1) +: 4] == 4'd0);
    end
    assign inc[4*g +: 4] = !cy[g] ? dig : (dig == 4'd9) ? 4'd0 : dig + 4'd1;
    assign dec[4*g +: 4] = !bw[g] ? dig : (dig == 4'd0) ? 4'd9 : dig - 4'd1;
  end

  assign at_max  = (q_q == LIMIT);
  assign at_zero = (q_q == '0);
  // With all digits valid, BCD ordering equals plain unsigned ordering.
  assign d_ok    = bcd_ok(D) && (D <= LIMIT);

`ifdef BCD_SAT_EN
  assign up_wrap = LIMIT;
  assign dn_wrap = '0;
`else
  assign up_wrap = '0;
  assign dn_wrap = LIMIT;
`endif

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (LOAD) begin
      if (d_ok) q_d   = D;
      else      err_d = 1'b1;
    end else if (ENABLE) begin
      if (UP) q_d = at_max  ? up_wrap : inc;
      else    q_d = at_zero ? dn_wrap : dec;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign ERR = err_q;
  assign CO  = ENABLE & (UP ? at_max : at_zero);

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboarded bench for bcd_counter_multi (2 digits, LIMIT=59) plus a two-instance chain.
module tb_bcd_counter_multi;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       ENABLE = 1'b0, LOAD = 1'b0, UP = 1'b1;
  logic [7:0] D = 8'h00;
  logic [7:0] Q;
  logic       CO, ERR;

  logic       c_en = 1'b0, c_load = 1'b0, c_up = 1'b1;
  logic [7:0] c_dlo = 8'h00, c_dhi = 8'h00;
  logic [7:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_err, hi_err;

  int errors = 0;
  int checks = 0;
  int mq     = 0;
`ifdef BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct { logic [7:0] q; logic err; } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  bcd_counter_multi #(.NUM_DIGITS(2), .LIMIT(8'h59)) dut (
    .CLK(CLK), .CLR(CLR), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP),
    .D(D), .Q(Q), .CO(CO), .ERR(ERR));

  bcd_counter_multi #(.NUM_DIGITS(2), .LIMIT(8'h59)) u_lo (
    .CLK(CLK), .CLR(CLR), .ENABLE(c_en), .LOAD(c_load), .UP(c_up),
    .D(c_dlo), .Q(lo_q), .CO(lo_co), .ERR(lo_err));

  bcd_counter_multi #(.NUM_DIGITS(2), .LIMIT(8'h59)) u_hi (
    .CLK(CLK), .CLR(CLR), .ENABLE(lo_co), .LOAD(c_load), .UP(c_up),
    .D(c_dhi), .Q(hi_q), .CO(hi_co), .ERR(hi_err));

  function automatic logic [7:0] i2b(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Drive one cycle, optionally check CO before the edge, push the model result, compare after.
  task automatic step(input string nm, input logic ld, input logic en, input logic up,
                      input logic [7:0] d, input logic chk_co);
    logic exp_co;
    exp_t e, got;
    LOAD = ld; ENABLE = en; UP = up; D = d;
    exp_co = en & (up ? (mq == 59) : (mq == 0));
    #3;
    if (chk_co) begin
      checks++;
      if (CO !== exp_co) begin
        errors++;
        $display("FAIL %s co: got %b want %b (mq=%0d)", nm, CO, exp_co, mq);
      end
    end
    e.err = 1'b0;
    if (ld) begin
      if (d[3:0] <= 4'd9 && d[7:4] <= 4'd9 && d <= 8'h59) mq = b2i(d);
      else e.err = 1'b1;
    end else if (en) begin
      if (up) mq = (mq == 59) ? (SAT ? 59 : 0) : mq + 1;
      else    mq = (mq == 0)  ? (SAT ? 0 : 59) : mq - 1;
    end
    e.q = i2b(mq);
    sb.push_back(e);
    @(posedge CLK); #1;
    got = sb.pop_front();
    checks++;
    if (Q !== got.q || ERR !== got.err) begin
      errors++;
      $display("FAIL %s: got q=%h err=%b want q=%h err=%b", nm, Q, ERR, got.q, got.err);
    end
  endtask

  task automatic test_reset();
    #2 CLR = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset: got q=%h err=%b want 00/0", Q, ERR);
    end
    LOAD = 1'b1; ENABLE = 1'b1; D = 8'h42;
    @(posedge CLK); #1;
    checks++;
    if (Q !== 8'h00) begin
      errors++;
      $display("FAIL reset_ignore_load: got q=%h want 00", Q);
    end
    LOAD = 1'b0; ENABLE = 1'b0;
    #2 CLR = 1'b1;
    @(posedge CLK); #1;
    mq = 0;
    checks++;
    if (Q !== 8'h00 || lo_q !== 8'h00 || hi_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got q=%h lo=%h hi=%h want 00", Q, lo_q, hi_q);
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 60; i++) step("count_up", 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    step("count_up_wrap", 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_count_down();
    step("ld00", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step("down_wrap", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    step("down_59", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    step("ld41", 1'b1, 1'b0, 1'b0, 8'h41, 1'b0);
    step("down_40", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    step("down_borrow", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_load();
    step("load_42", 1'b1, 1'b1, 1'b1, 8'h42, 1'b1);
    step("load_bad_nib", 1'b1, 1'b1, 1'b1, 8'h4A, 1'b0);
    step("err_clear", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    step("load_over", 1'b1, 1'b0, 1'b1, 8'h60, 1'b0);
    step("err_clear2", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    step("load_limit", 1'b1, 1'b0, 1'b1, 8'h59, 1'b0);
    step("load_low_bad", 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0);
    step("load_bad_back", 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0);
  endtask

  task automatic test_hold();
    step("ld25", 1'b1, 1'b0, 1'b1, 8'h25, 1'b0);
    for (int i = 0; i < 10; i++) step("hold", 1'b0, 1'b0, (i % 2) == 0, 8'h00, 1'b1);
    step("hold_up_step", 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    step("dir_change", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_clr_mid();
    step("ld30", 1'b1, 1'b0, 1'b1, 8'h30, 1'b0);
    for (int i = 0; i < 7; i++) step("to37", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    #2 CLR = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL clr_async: got q=%h err=%b want 00/0", Q, ERR);
    end
    mq = 0;
    @(posedge CLK); #1;
    ENABLE = 1'b0;
    CLR = 1'b1;
    step("after_clr", 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_chain();
    logic [15:0] want;
    c_load = 1'b1; c_dlo = 8'h58; c_dhi = 8'h59; c_en = 1'b0; c_up = 1'b1;
    @(posedge CLK); #1;
    c_load = 1'b0; c_en = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({hi_q, lo_q} !== 16'h5959) begin
      errors++;
      $display("FAIL chain_5959: got %h want 5959", {hi_q, lo_q});
    end
    #3;
    checks++;
    if (lo_co !== 1'b1 || hi_co !== 1'b1) begin
      errors++;
      $display("FAIL chain_co: got lo=%b hi=%b want 1/1", lo_co, hi_co);
    end
    @(posedge CLK); #1;
    want = SAT ? 16'h5959 : 16'h0000;
    checks++;
    if ({hi_q, lo_q} !== want) begin
      errors++;
      $display("FAIL chain_roll: got %h want %h", {hi_q, lo_q}, want);
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_clr_mid();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-digit BCD up/down counter with synchronous parallel load, programmable wrap limit and cascadable terminal-count output.
- Replaces the single-digit BCD counter wherever counters are wider than one digit or have a non-decimal-power modulus (0-59 timers, 0-23 hours, display counters).
- Chains to further instances through CO feeding the next instance's ENABLE.

Parameters:
- NUM_DIGITS, 2, number of BCD digits; Q and D are 4*NUM_DIGITS bits wide. Range 1..8.
- LIMIT, {NUM_DIGITS{4'h9}}, BCD-encoded maximum count; the counter wraps from LIMIT to 0. Every nibble must be 0-9 and LIMIT must be nonzero; otherwise elaboration stops with an error.

Ports:
- CLK, in, 1, clock; all state updates on the rising edge.
- CLR, in, 1, asynchronous active-low reset; 0 clears immediately.
- ENABLE, in, 1, count enable; 1 counts one step per CLK edge.
- LOAD, in, 1, synchronous parallel load of D.
- UP, in, 1, direction: 1 = up, 0 = down.
- D, in, 4*NUM_DIGITS, BCD load value; digit 0 is at D[3:0].
- Q, out, 4*NUM_DIGITS, current BCD count; registered.
- CO, out, 1, terminal count (carry or borrow); combinational.
- ERR, out, 1, load-rejected flag; registered, one-cycle pulse.

Behaviour:
- Reset:
  - CLR=0 forces Q=0 and ERR=0 asynchronously.
  - While CLR=0, LOAD and ENABLE are ignored.
  - Counting resumes on the first CLK edge after CLR returns to 1.
- Priority per edge: CLR > LOAD > ENABLE > hold.
- LOAD=1 (ENABLE is don't-care):
  - If every nibble of D is 0-9 and D <= LIMIT, then Q <= D and ERR <= 0.
  - Otherwise Q holds its value and ERR <= 1 for exactly one cycle.
  - The numeric comparison is a plain unsigned compare of the packed vectors. This is valid because BCD ordering with valid digits equals binary ordering.
- ENABLE=1, LOAD=0, UP=1:
  - If Q == LIMIT, then Q <= 0.
  - Otherwise Q is BCD-incremented: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit; a carry ripples only while all lower digits are at 9.
- ENABLE=1, LOAD=0, UP=0:
  - If Q == 0, then Q <= LIMIT.
  - Otherwise Q is BCD-decremented: a digit at 0 goes to 9 and borrows from the next digit.
- ENABLE=0, LOAD=0: Q holds.
- Cycles with no LOAD: ERR <= 0.
- CO = ENABLE & ((UP & Q==LIMIT) | (~UP & Q==0)).
  - Asserts in the cycle before the wrap, so a downstream instance clocked by the same CLK steps on the same edge.
  - CO is independent of LOAD.
- Invariant: Q is always valid BCD and Q <= LIMIT. This holds because all entry paths (reset, load, count) preserve it.
- UP may change on any cycle; the new direction takes effect on the next edge.
- Latency: one CLK edge from LOAD or ENABLE to Q update; CO has zero latency from ENABLE, UP and Q.

Optional Feature:
- Macro: BCD_SAT_EN.
- Defined: saturating mode.
  - Counting up at Q == LIMIT holds Q at LIMIT.
  - Counting down at Q == 0 holds Q at 0.
  - CO still asserts by the same equation, acting as an "at bound" indicator.
  - Load rules are unchanged.
- Undefined: wrap behaviour as specified in Behaviour.
- Port list is identical in both builds.

Test Plan:
- NUM_DIGITS=2, LIMIT=8'h59, CLR pulsed low mid-count at Q=8'h37 -> Q=8'h00 immediately, without waiting for a CLK edge; ERR=0.
- Count up from 0 with ENABLE=1, UP=1, for 60 edges -> Q steps 00,01,...,09,10,...,59; CO=1 only while Q=8'h59; next edge gives Q=8'h00.
- UP=0 from Q=8'h00 -> CO=1, then Q=8'h59,8'h58; a borrow across digits gives Q=8'h40 followed by 8'h39.
- LOAD with D=8'h42 and ENABLE=1 -> Q=8'h42 and ERR=0. LOAD with D=8'h4A (invalid nibble) or D=8'h60 (> LIMIT) -> Q unchanged, ERR=1 for exactly one cycle.
- ENABLE=0 for 10 edges at Q=8'h25 -> Q holds 8'h25 and CO=0. Two instances chained (CO to ENABLE) -> combined count rolls from 5959 to 0000 on a single edge.
- With BCD_SAT_EN defined: count up at Q=8'h59 -> Q stays 8'h59 and CO=1; count down at Q=8'h00 -> Q stays 8'h00.
